// File: rtl/siganfu_turret_controller.sv
// Fire-control FSM for the Siganfu weapon family: single/burst/auto fire, magazine
// bookkeeping, timed reload, overheat cooldown and terminal depletion.
module siganfu_turret_controller #(
   parameter int MAG_SIZE   = 25,
   parameter int MAG_COUNT  = 3,
   parameter int BURST_LEN  = 3,
   parameter int PULSE_CYC  = 5,
   parameter int GAP_CYC    = 20,
   parameter int RELOAD_CYC = 50,
   parameter int COOL_CYC   = 100,
   localparam int RW = $clog2(MAG_SIZE + 1),
   localparam int MW = (MAG_COUNT > 0) ? $clog2(MAG_COUNT + 1) : 1
) (
   input  logic          sysclk,
   input  logic          reboot_n,
   input  logic          target_locked,
   input  logic          is_enemy,
   input  logic          fire_command,
   input  logic [1:0]    firing_mode,
   input  logic          overheat_sensor,
   output logic [2:0]    current_state,
   output logic          fire_trigger,
   output logic          criticality_alert,
   output logic [RW-1:0] rounds_left,
   output logic [MW-1:0] mags_left
);

   localparam int TMAX_A = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
   localparam int TMAX_B = (RELOAD_CYC > COOL_CYC) ? RELOAD_CYC : COOL_CYC;
   localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
   localparam int TW     = $clog2(TMAX + 1);
   localparam int BW     = $clog2(BURST_LEN + 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SINGLE   = 3'd1,
      S_AUTO     = 3'd2,
      S_RELOAD   = 3'd3,
      S_OVERHEAT = 3'd4,
      S_DEPLETED = 3'd5,
      S_BURST    = 3'd6
   } state_t;

   state_t        state_r;
   logic          fire_r;
   logic          alert_r;
   logic [RW-1:0] rounds_r;
   logic [MW-1:0] mags_r;
   logic [TW-1:0] timer_r;
   logic [BW-1:0] burst_cnt_r;
   logic          active_r;     // a pulse or its trailing gap is in progress
   logic          shot_done_r;  // SINGLE has already spent its round

   logic engage_s;
   logic slot_s;
   logic want_shot_s;
   logic hold_s;

   assign current_state     = state_r;
   assign fire_trigger      = fire_r;
   assign criticality_alert = alert_r;
   assign rounds_left       = rounds_r;
   assign mags_left         = mags_r;

   assign engage_s = target_locked & is_enemy & fire_command;
   // A decision point: nothing in flight, or the last gap cycle where the next round may follow back-to-back
   assign slot_s   = !active_r || (!fire_r && (timer_r == TW'(GAP_CYC - 1)));

   // Per-mode permission to start another round at a decision point
   always_comb begin
      want_shot_s = 1'b0;
      hold_s      = 1'b0;
      case (state_r)
         S_SINGLE: begin
            want_shot_s = engage_s && !shot_done_r;
            hold_s      = shot_done_r && fire_command;
         end
         S_BURST:  want_shot_s = engage_s && (burst_cnt_r < BW'(BURST_LEN));
         S_AUTO:   want_shot_s = engage_s;
         default: begin
            want_shot_s = 1'b0;
            hold_s      = 1'b0;
         end
      endcase
   end

   // Main controller FSM with all registered outputs and timers
   always_ff @(posedge sysclk or negedge reboot_n) begin
      if (!reboot_n) begin
         state_r     <= S_IDLE;
         fire_r      <= 1'b0;
         alert_r     <= (MAG_COUNT == 0);
         rounds_r    <= RW'(MAG_SIZE);
         mags_r      <= MW'(MAG_COUNT);
         timer_r     <= '0;
         burst_cnt_r <= '0;
         active_r    <= 1'b0;
         shot_done_r <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               fire_r      <= 1'b0;
               timer_r     <= '0;
               active_r    <= 1'b0;
               burst_cnt_r <= '0;
               shot_done_r <= 1'b0;
               if (rounds_r == RW'(0)) begin
                  state_r <= (mags_r != MW'(0)) ? S_RELOAD : S_DEPLETED;
               end else if (overheat_sensor) begin
                  state_r <= S_OVERHEAT;
               end else if (engage_s) begin
                  case (firing_mode)
                     2'b00:   state_r <= S_SINGLE;
                     2'b01:   state_r <= S_BURST;
                     default: state_r <= S_AUTO;
                  endcase
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_SINGLE, S_BURST, S_AUTO: begin
               if (overheat_sensor) begin
                  state_r  <= S_OVERHEAT;
                  fire_r   <= 1'b0;
                  active_r <= 1'b0;
                  timer_r  <= '0;
               end else if (!slot_s) begin
                  if (fire_r && (timer_r == TW'(PULSE_CYC - 1))) begin
                     fire_r  <= 1'b0;
                     timer_r <= '0;
                  end else begin
                     timer_r <= timer_r + TW'(1);
                  end
               end else if (rounds_r == RW'(0)) begin
                  state_r  <= (mags_r != MW'(0)) ? S_RELOAD : S_DEPLETED;
                  active_r <= 1'b0;
                  timer_r  <= '0;
               end else if (want_shot_s) begin
                  fire_r      <= 1'b1;
                  active_r    <= 1'b1;
                  timer_r     <= '0;
                  rounds_r    <= rounds_r - RW'(1);
                  shot_done_r <= 1'b1;
                  if (burst_cnt_r < BW'(BURST_LEN)) begin
                     burst_cnt_r <= burst_cnt_r + BW'(1);
                  end else begin
                     burst_cnt_r <= burst_cnt_r;
                  end
               end else if (hold_s) begin
                  active_r <= 1'b0;
                  timer_r  <= '0;
               end else begin
                  state_r  <= S_IDLE;
                  active_r <= 1'b0;
                  timer_r  <= '0;
               end
            end
            S_RELOAD: begin
               fire_r   <= 1'b0;
               active_r <= 1'b0;
               if (overheat_sensor) begin
                  state_r <= S_OVERHEAT;
                  timer_r <= '0;
               end else if (timer_r == TW'(RELOAD_CYC - 1)) begin
                  state_r  <= S_IDLE;
                  timer_r  <= '0;
                  rounds_r <= RW'(MAG_SIZE);
                  if (mags_r != MW'(0)) begin
                     mags_r <= mags_r - MW'(1);
                  end else begin
                     mags_r <= mags_r;
                  end
                  if (mags_r == MW'(1)) begin
                     alert_r <= 1'b1;
                  end else begin
                     alert_r <= alert_r;
                  end
               end else begin
                  timer_r <= timer_r + TW'(1);
               end
            end
            S_OVERHEAT: begin
               fire_r   <= 1'b0;
               active_r <= 1'b0;
               if (overheat_sensor) begin
                  timer_r <= '0;
               end else if (timer_r == TW'(COOL_CYC - 1)) begin
                  timer_r <= '0;
                  if (rounds_r != RW'(0)) begin
                     state_r <= S_IDLE;
                  end else if (mags_r != MW'(0)) begin
                     state_r <= S_RELOAD;
                  end else begin
                     state_r <= S_DEPLETED;
                  end
               end else begin
                  timer_r <= timer_r + TW'(1);
               end
            end
            S_DEPLETED: begin
               fire_r   <= 1'b0;
               active_r <= 1'b0;
               timer_r  <= '0;
               state_r  <= S_DEPLETED;
            end
            default: begin
               state_r  <= S_IDLE;
               fire_r   <= 1'b0;
               active_r <= 1'b0;
               timer_r  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_siganfu_turret_controller.sv
// Directed self-checking bench for siganfu_turret_controller at default parameters.
module tb_siganfu_turret_controller;

   logic       sysclk = 1'b0;
   logic       reboot_n;
   logic       target_locked;
   logic       is_enemy;
   logic       fire_command;
   logic [1:0] firing_mode;
   logic       overheat_sensor;
   logic [2:0] current_state;
   logic       fire_trigger;
   logic       criticality_alert;
   logic [4:0] rounds_left;
   logic [1:0] mags_left;

   int n_checks = 0;
   int n_fail   = 0;

   siganfu_turret_controller dut (
      .sysclk            (sysclk),
      .reboot_n          (reboot_n),
      .target_locked     (target_locked),
      .is_enemy          (is_enemy),
      .fire_command      (fire_command),
      .firing_mode       (firing_mode),
      .overheat_sensor   (overheat_sensor),
      .current_state     (current_state),
      .fire_trigger      (fire_trigger),
      .criticality_alert (criticality_alert),
      .rounds_left       (rounds_left),
      .mags_left         (mags_left)
   );

   always #5 sysclk = ~sysclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge sysclk);
   endtask

   // Wait (bounded) until the FSM reports state st; an expired budget shows up as a failed check
   task automatic wait_state(input string tag, input logic [2:0] st, input int budget, output int waited);
      waited = 0;
      while (current_state !== st && waited < budget) begin
         @(negedge sysclk);
         waited++;
      end
      check(tag, 32'(current_state), 32'(st));
   endtask

   task automatic do_reset();
      @(negedge sysclk);
      reboot_n = 1'b0;
      step(2);
      reboot_n = 1'b1;
      step(1);
   endtask

   task automatic set_engage(input logic on, input logic [1:0] mode);
      target_locked = 1'b1;
      is_enemy      = 1'b1;
      firing_mode   = mode;
      fire_command  = on;
   endtask

   initial begin
      int  hi;
      int  rises;
      int  waited;
      int  total;
      int  p[3];
      logic prev;
      logic [1:0] alert_mags;
      logic alert_seen;

      reboot_n        = 1'b0;
      target_locked   = 1'b0;
      is_enemy        = 1'b0;
      fire_command    = 1'b0;
      firing_mode     = 2'b00;
      overheat_sensor = 1'b0;
      step(2);
      check("rst_state",  32'(current_state), 32'd0);
      check("rst_fire",   32'(fire_trigger), 32'd0);
      check("rst_alert",  32'(criticality_alert), 32'd0);
      check("rst_rounds", 32'(rounds_left), 32'd25);
      check("rst_mags",   32'(mags_left), 32'd3);
      reboot_n = 1'b1;
      step(1);

      // Single mode: one pulse while held, IDLE only after fire_command drops
      set_engage(1'b1, 2'b00);
      step(1);
      check("single_entry_state", 32'(current_state), 32'd1);
      check("single_entry_fire",  32'(fire_trigger), 32'd0);
      step(1);
      check("single_latency_fire", 32'(fire_trigger), 32'd1);
      check("single_rounds",       32'(rounds_left), 32'd24);
      hi = 1; rises = 1; prev = 1'b1;
      for (int i = 0; i < 198; i++) begin
         step(1);
         if (fire_trigger) hi++;
         if (fire_trigger && !prev) rises++;
         prev = fire_trigger;
      end
      check("single_pulse_len",   32'(hi), 32'd5);
      check("single_pulse_count", 32'(rises), 32'd1);
      check("single_held_state",  32'(current_state), 32'd1);
      check("single_rounds_end",  32'(rounds_left), 32'd24);
      fire_command = 1'b0;
      step(1);
      check("single_release_idle", 32'(current_state), 32'd0);

      // Burst mode: 3 pulses at 25-cycle period, IDLE after the last gap
      do_reset();
      set_engage(1'b1, 2'b01);
      rises = 0; prev = 1'b0;
      for (int k = 1; k <= 76; k++) begin
         step(1);
         if (fire_trigger && !prev) begin
            if (rises < 3) p[rises] = k;
            rises++;
         end
         prev = fire_trigger;
         if (k == 60) fire_command = 1'b0;
      end
      check("burst_count",   32'(rises), 32'd3);
      check("burst_first",   32'(p[0]), 32'd2);
      check("burst_period1", 32'(p[1] - p[0]), 32'd25);
      check("burst_period2", 32'(p[2] - p[1]), 32'd25);
      check("burst_gap_state", 32'(current_state), 32'd6);
      step(1);
      check("burst_idle",   32'(current_state), 32'd0);
      check("burst_rounds", 32'(rounds_left), 32'd22);
      step(10);
      check("burst_stay_idle", 32'(current_state), 32'd0);
      fire_command = 1'b1;
      step(2);
      check("burst2_fire",   32'(fire_trigger), 32'd1);
      check("burst2_rounds", 32'(rounds_left), 32'd21);

      // Auto mode through all magazines to DEPLETED
      do_reset();
      set_engage(1'b1, 2'b10);
      rises = 0; prev = 1'b0; waited = 0;
      while (current_state !== 3'd3 && waited < 700) begin
         step(1);
         waited++;
         if (fire_trigger && !prev) rises++;
         prev = fire_trigger;
      end
      check("auto_reload_state", 32'(current_state), 32'd3);
      check("auto_mag1_pulses",  32'(rises), 32'd25);
      check("auto_reload_rounds", 32'(rounds_left), 32'd0);
      waited = 0;
      while (current_state === 3'd3 && waited < 100) begin
         step(1);
         waited++;
      end
      check("reload_len",    32'(waited), 32'd50);
      check("reload_rounds", 32'(rounds_left), 32'd25);
      check("reload_mags",   32'(mags_left), 32'd2);
      total = 25; prev = 1'b0; waited = 0; alert_seen = 1'b0; alert_mags = 2'd3;
      while (current_state !== 3'd5 && waited < 3000) begin
         step(1);
         waited++;
         if (fire_trigger && !prev) total++;
         prev = fire_trigger;
         if (criticality_alert && !alert_seen) begin
            alert_seen = 1'b1;
            alert_mags = mags_left;
         end
      end
      check("depleted_state",  32'(current_state), 32'd5);
      check("depleted_rounds", 32'(total), 32'd100);
      check("alert_at_mags0",  32'(alert_mags), 32'd0);
      check("depleted_alert",  32'(criticality_alert), 32'd1);
      check("depleted_rl",     32'(rounds_left), 32'd0);
      check("depleted_ml",     32'(mags_left), 32'd0);
      step(20);
      check("depleted_stays",  32'(current_state), 32'd5);
      check("depleted_fire",   32'(fire_trigger), 32'd0);
      reboot_n = 1'b0;
      #1;
      check("reboot_dep_state",  32'(current_state), 32'd0);
      check("reboot_dep_rounds", 32'(rounds_left), 32'd25);
      check("reboot_dep_mags",   32'(mags_left), 32'd3);
      check("reboot_dep_alert",  32'(criticality_alert), 32'd0);
      step(1);
      reboot_n = 1'b1;
      step(1);

      // Overheat mid-pulse, then cooldown interrupted by one hot cycle
      set_engage(1'b1, 2'b10);
      step(3);
      check("oh_pulse_on", 32'(fire_trigger), 32'd1);
      overheat_sensor = 1'b1;
      fire_command    = 1'b0;
      step(1);
      check("oh_fire_cut", 32'(fire_trigger), 32'd0);
      check("oh_state",    32'(current_state), 32'd4);
      check("oh_rounds",   32'(rounds_left), 32'd24);
      overheat_sensor = 1'b0;
      step(60);
      overheat_sensor = 1'b1;
      step(1);
      overheat_sensor = 1'b0;
      step(99);
      check("oh_cool_99", 32'(current_state), 32'd4);
      step(1);
      check("oh_cool_idle", 32'(current_state), 32'd0);

      // Overheat at reload cycle 30: reload restarts after cooldown
      do_reset();
      set_engage(1'b1, 2'b10);
      wait_state("r5_reload", 3'd3, 700, waited);
      fire_command = 1'b0;
      step(30);
      overheat_sensor = 1'b1;
      step(1);
      check("r5_oh_state", 32'(current_state), 32'd4);
      check("r5_oh_mags",  32'(mags_left), 32'd3);
      overheat_sensor = 1'b0;
      step(99);
      check("r5_cooling", 32'(current_state), 32'd4);
      step(1);
      check("r5_back_reload", 32'(current_state), 32'd3);
      step(49);
      check("r5_reload_49", 32'(current_state), 32'd3);
      step(1);
      check("r5_done_idle",   32'(current_state), 32'd0);
      check("r5_done_rounds", 32'(rounds_left), 32'd25);
      check("r5_done_mags",   32'(mags_left), 32'd2);

      // Asynchronous reboot in the middle of a burst pulse
      set_engage(1'b1, 2'b01);
      step(3);
      check("mid_burst_fire", 32'(fire_trigger), 32'd1);
      #2;
      reboot_n = 1'b0;
      #1;
      check("reboot_mid_state",  32'(current_state), 32'd0);
      check("reboot_mid_fire",   32'(fire_trigger), 32'd0);
      check("reboot_mid_rounds", 32'(rounds_left), 32'd25);
      check("reboot_mid_mags",   32'(mags_left), 32'd3);
      check("reboot_mid_alert",  32'(criticality_alert), 32'd0);
      step(1);
      reboot_n = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
